// File: rtl/chess_pkg.sv
// Shared types and constants for the chess engine front end: piece codes,
// side encoding, cursor FSM states and the reset/idle squares.
package chess_pkg;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_t;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_TARGET = 2'd1,
        S_WAIT   = 2'd2,
        S_UNUSED = 2'd3
    } cursor_state_t;

    localparam logic [2:0] RST_CUR_X = 3'd6;
    localparam logic [2:0] RST_CUR_Y = 3'd4;
    // Empty square at game start, so a committed idle coordinate does nothing.
    localparam logic [2:0] IDLE_X    = 3'd4;
    localparam logic [2:0] IDLE_Y    = 3'd0;

endpackage

// File: rtl/btn_debounce.sv
// One board button: 2-FF synchroniser, stability counter and a one-cycle
// registered press pulse on each accepted 0->1 change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic             sync1, sync2, level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Pulse is registered alongside the level so it lands 2+N cycles after the raw edge.
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chess_cursor_ctrl.sv
// Button front end for chess_engine: debounced cursor movement, square commit
// on centre press, select/target/wait tracking and the side-to-move register.
module chess_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17,
    parameter int MOVE_TIMEOUT    = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    input  logic       moved,
    output logic [2:0] coordX,
    output logic [2:0] coordY,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       src_valid,
    output logic [2:0] src_x,
    output logic [2:0] src_y,
    output logic       player,
    output logic [1:0] state
);

    localparam int TO_W = $clog2(MOVE_TIMEOUT + 1);

    logic [4:0]      raw, press;
    logic            act_c, act_u, act_d, act_l, act_r;
    cursor_state_t   st;
    logic [TO_W-1:0] tcnt;

    assign raw   = {btnC, btnU, btnD, btnL, btnR};
    assign state = st;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (CLOCK),
            .rst  (RESET),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    // Only the highest-priority pulse in a cycle acts: C > U > D > L > R.
    always_comb begin
        act_c = 1'b0;
        act_u = 1'b0;
        act_d = 1'b0;
        act_l = 1'b0;
        act_r = 1'b0;
        if (press[4])      act_c = 1'b1;
        else if (press[3]) act_u = 1'b1;
        else if (press[2]) act_d = 1'b1;
        else if (press[1]) act_l = 1'b1;
        else if (press[0]) act_r = 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cursor_x <= RST_CUR_X;
            cursor_y <= RST_CUR_Y;
        end else begin
            if (act_u && cursor_x != 3'd0) cursor_x <= cursor_x - 3'd1;
            if (act_d && cursor_x != 3'd7) cursor_x <= cursor_x + 3'd1;
            if (act_l && cursor_y != 3'd0) cursor_y <= cursor_y - 3'd1;
            if (act_r && cursor_y != 3'd7) cursor_y <= cursor_y + 3'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            st        <= S_SELECT;
            coordX    <= IDLE_X;
            coordY    <= IDLE_Y;
            src_valid <= 1'b0;
            src_x     <= 3'd0;
            src_y     <= 3'd0;
            player    <= WHITE;
            tcnt      <= '0;
        end else begin
            case (st)
                S_SELECT: if (act_c) begin
                    coordX    <= cursor_x;
                    coordY    <= cursor_y;
                    src_x     <= cursor_x;
                    src_y     <= cursor_y;
                    src_valid <= 1'b1;
                    st        <= S_TARGET;
                end
                S_TARGET: if (act_c) begin
                    if (cursor_x == src_x && cursor_y == src_y) begin
                        src_valid <= 1'b0;
                        st        <= S_SELECT;
                    end else begin
                        coordX <= cursor_x;
                        coordY <= cursor_y;
                        tcnt   <= '0;
                        st     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (moved) begin
                        player    <= ~player;
                        src_valid <= 1'b0;
                        st        <= S_SELECT;
                    end else if (tcnt == TO_W'(MOVE_TIMEOUT - 1)) begin
                        // Rejected target: the clicked square becomes the nominal source.
                        src_x <= coordX;
                        src_y <= coordY;
                        st    <= S_TARGET;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: st <= S_SELECT;
            endcase
        end
    end

endmodule
